// File: rtl/ball_motion.sv
// ball_motion: ball engine for the brick-breaker game.
// Moves an SIZE x SIZE ball across a 640x480 screen once per tick, reflects it
// off the walls, the paddle and bricks, and handles serve, miss and lives.
//
// Ports
//   clk, rst           system clock, asynchronous active-low reset
//   launch_n           serve button (active-low, asynchronous to clk)
//   paddle_*           live paddle geometry from the paddle block
//   brick_hit          one-cycle request for a vertical reflection
//   x, y, active_pixels VGA scan position and visible-area flag
//   vga_color          ball colour layer (combinational)
//   ball_x, ball_y     registered ball top-left position
//   ball_size          constant SIZE
//   lives, game_over   remaining lives, game-over flag
//   ball_lost          one-cycle pulse when the ball is missed
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SERVE     | ball rides on the paddle, waiting for a launch press
// MOVING    | ball in flight, updated once per tick
// LOST      | ball missed; frozen for LOST_TICKS ticks
// GAME_OVER | no lives left; ball hidden until reset
module ball_motion #(
  parameter int TICK_MAX   = 208333,
  parameter int SIZE       = 8,
  parameter int LIVES      = 3,
  parameter int LOST_TICKS = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch_n,
  input  logic [9:0]  paddle_x,
  input  logic [9:0]  paddle_y,
  input  logic [9:0]  paddle_width,
  input  logic [9:0]  paddle_height,
  input  logic        brick_hit,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_pixels,
  output logic [23:0] vga_color,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [9:0]  ball_size,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic        ball_lost
);

  typedef enum logic [1:0] {SERVE, MOVING, LOST, GAME_OVER} state_t;

  localparam int          LCW      = $clog2(LOST_TICKS) + 1;
  localparam logic [19:0] TICK_W   = 20'(TICK_MAX);
  localparam logic [10:0] SIZE_W   = 11'(SIZE);
  localparam logic [10:0] HALF_W   = 11'(SIZE / 2);
  localparam logic [10:0] SCR_W    = 11'd640;
  localparam logic [10:0] SCR_H    = 11'd480;
  localparam logic [9:0]  RST_X    = 10'd316;
  localparam logic [9:0]  RST_Y    = 10'd432;

  state_t           state, state_n;
  logic [19:0]      tick_cnt;
  logic             tick;
  logic             sync_1, sync_2, launch_q;
  logic [1:0]       warm;
  logic             launch_evt;
  logic             dx, dy, dx_n, dy_n;
  logic [9:0]       ball_x_n, ball_y_n;
  logic [2:0]       lives_n;
  logic             ball_lost_n;
  logic [LCW-1:0]   lost_cnt, lost_cnt_n;
  logic             pending, pending_n;

  // 11-bit views so "+SIZE" and "+width" never wrap in comparisons
  logic [10:0] bx, by, px, py, pw, xx, yy, centre, quarter;
  logic        miss, paddle_hit, steer_left, steer_right, in_ball;
  logic [9:0]  serve_x, serve_y;

  // Only the paddle's top edge matters for contact.
  logic unused_paddle_height;
  assign unused_paddle_height = ^paddle_height;

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign px = {1'b0, paddle_x};
  assign py = {1'b0, paddle_y};
  assign pw = {1'b0, paddle_width};
  assign xx = {1'b0, x};
  assign yy = {1'b0, y};

  assign tick = (tick_cnt == TICK_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 20'd1;
  end

  // Two-flop synchronizer plus edge register. The warm-up counter keeps the
  // reset value of the flops from looking like a press when the button is
  // already held as reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1   <= 1'b1;
      sync_2   <= 1'b1;
      launch_q <= 1'b1;
      warm     <= 2'd0;
    end else begin
      sync_1   <= launch_n;
      sync_2   <= sync_1;
      launch_q <= sync_2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign launch_evt = (warm == 2'd3) && launch_q && !sync_2;

  assign serve_x = paddle_x + (paddle_width >> 1) - 10'(SIZE / 2);
  assign serve_y = paddle_y - 10'(SIZE);

  assign miss        = dy && ((by + SIZE_W) >= SCR_H);
  assign paddle_hit  = dy && ((by + SIZE_W) == py) && ((bx + SIZE_W) > px) && (bx < (px + pw));
  assign centre      = bx + HALF_W;
  assign quarter     = pw >> 2;
  assign steer_left  = centre < (px + quarter);
  assign steer_right = centre >= (px + pw - quarter);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SERVE;
      ball_x    <= RST_X;
      ball_y    <= RST_Y;
      dx        <= 1'b1;
      dy        <= 1'b0;
      lives     <= 3'(LIVES);
      ball_lost <= 1'b0;
      lost_cnt  <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_n;
      ball_x    <= ball_x_n;
      ball_y    <= ball_y_n;
      dx        <= dx_n;
      dy        <= dy_n;
      lives     <= lives_n;
      ball_lost <= ball_lost_n;
      lost_cnt  <= lost_cnt_n;
      pending   <= pending_n;
    end
  end

  always_comb begin
    state_n     = state;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    dx_n        = dx;
    dy_n        = dy;
    lives_n     = lives;
    ball_lost_n = 1'b0;
    lost_cnt_n  = lost_cnt;
    pending_n   = 1'b0;
    case (state)
      SERVE: begin
        ball_x_n = serve_x;
        ball_y_n = serve_y;
        if (launch_evt) begin
          state_n = MOVING;
          dx_n    = 1'b1;
          dy_n    = 1'b0;
        end
      end
      MOVING: begin
        pending_n = pending || brick_hit;
        if (tick) begin
          pending_n = 1'b0;
          if (miss) begin
            state_n     = LOST;
            lives_n     = lives - 3'd1;
            ball_lost_n = 1'b1;
            lost_cnt_n  = LCW'(LOST_TICKS - 1);
          end else begin
            if (paddle_hit) begin
              dy_n = 1'b0;
              if (steer_left)       dx_n = 1'b0;
              else if (steer_right) dx_n = 1'b1;
            end else if (pending || brick_hit) begin
              dy_n = !dy;
            end
            // Walls are checked against the already-updated flags so a
            // paddle/brick decision can never push the ball off screen.
            if (dx_n && ((bx + SIZE_W) >= SCR_W))  dx_n = 1'b0;
            else if (!dx_n && (ball_x == 10'd0))   dx_n = 1'b1;
            if (!dy_n && (ball_y == 10'd0))        dy_n = 1'b1;
            ball_x_n = dx_n ? ball_x + 10'd1 : ball_x - 10'd1;
            ball_y_n = dy_n ? ball_y + 10'd1 : ball_y - 10'd1;
          end
        end
      end
      LOST: begin
        if (tick) begin
          if (lost_cnt == '0) state_n = (lives != 3'd0) ? SERVE : GAME_OVER;
          else                lost_cnt_n = lost_cnt - LCW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  assign in_ball = active_pixels && (state != GAME_OVER) &&
                   (xx >= bx) && (xx < (bx + SIZE_W)) &&
                   (yy >= by) && (yy < (by + SIZE_W));

  assign vga_color = in_ball ? 24'hFFFFFF : 24'h000000;
  assign ball_size = 10'(SIZE);
  assign game_over = (state == GAME_OVER);

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;

  localparam int TM   = 3;
  localparam int STEP = 2 * (TM + 1) + 2;

  logic        clk = 1'b0;
  logic        rst, launch_n, brick_hit, active_pixels;
  logic [9:0]  paddle_x, paddle_y, paddle_width, paddle_height, x, y;
  logic [23:0] vga_color;
  logic [9:0]  ball_x, ball_y, ball_size;
  logic [2:0]  lives;
  logic        game_over, ball_lost;

  int nvec  = 0;
  int nfail = 0;

  ball_motion #(.TICK_MAX(TM)) dut (
    .clk(clk), .rst(rst), .launch_n(launch_n),
    .paddle_x(paddle_x), .paddle_y(paddle_y),
    .paddle_width(paddle_width), .paddle_height(paddle_height),
    .brick_hit(brick_hit), .x(x), .y(y), .active_pixels(active_pixels),
    .vga_color(vga_color), .ball_x(ball_x), .ball_y(ball_y),
    .ball_size(ball_size), .lives(lives), .game_over(game_over),
    .ball_lost(ball_lost)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [9:0]  px, pw, py, pix_x, pix_y;
    logic        act;
    logic [9:0]  exp_bx, exp_by;
    logic [23:0] exp_col;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_pos(input string name, input logic [9:0] ex, input logic [9:0] ey);
    check({name, "_x"}, 32'(ball_x), 32'(ex));
    check({name, "_y"}, 32'(ball_y), 32'(ey));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Waits for n position changes (one per tick in flight), then checks position.
  task automatic wait_moves(input int n, input string name, input logic [9:0] ex, input logic [9:0] ey);
    logic [9:0] ox, oy;
    bit moved;
    for (int i = 0; i < n; i++) begin
      ox = ball_x;
      oy = ball_y;
      moved = 0;
      for (int c = 0; c < STEP && !moved; c++) begin
        step();
        if (ball_x !== ox || ball_y !== oy) moved = 1;
      end
      if (!moved) begin
        timeout(name);
        return;
      end
    end
    check_pos(name, ex, ey);
  endtask

  task automatic wait_lost(input int budget, input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      if (c == 10) launch_n = 1'b1;
      if (ball_lost === 1'b1) seen = 1;
    end
    if (!seen) timeout(name);
  endtask

  initial begin
    tbl[0]  = '{270, 100, 440, 316, 432, 1, 316, 432, 24'hFFFFFF};
    tbl[1]  = '{300, 100, 440, 346, 432, 1, 346, 432, 24'hFFFFFF};
    tbl[2]  = '{0,    64, 400,  27, 392, 1,  28, 392, 24'h000000};
    tbl[3]  = '{500, 101, 300, 553, 299, 1, 546, 292, 24'hFFFFFF};
    tbl[4]  = '{100,   8,  20, 108,  12, 1, 100,  12, 24'h000000};
    tbl[5]  = '{270, 100, 440, 323, 439, 1, 316, 432, 24'hFFFFFF};
    tbl[6]  = '{270, 100, 440, 316, 440, 1, 316, 432, 24'h000000};
    tbl[7]  = '{270, 100, 440, 320, 436, 0, 316, 432, 24'h000000};
    tbl[8]  = '{270, 100, 440, 316, 431, 1, 316, 432, 24'h000000};
    tbl[9]  = '{1000, 40,  10, 1023,  2, 1, 1016,  2, 24'hFFFFFF};
    tbl[10] = '{270, 100, 440,   0,   0, 1, 316, 432, 24'h000000};

    rst = 1'b1; launch_n = 1'b1; brick_hit = 1'b0; active_pixels = 1'b0;
    paddle_x = 10'd270; paddle_y = 10'd440; paddle_width = 10'd100; paddle_height = 10'd20;
    x = 10'd0; y = 10'd0;

    // reset values
    #3 rst = 1'b0;
    #1;
    check_pos("reset", 10'd316, 10'd432);
    check("reset_lives", 32'(lives), 32'd3);
    check("reset_game_over", 32'(game_over), 32'd0);
    check("reset_ball_lost", 32'(ball_lost), 32'd0);
    check("ball_size", 32'(ball_size), 32'd8);
    repeat (3) step();
    rst = 1'b1;
    step();

    // serve tracking and colour layer
    for (int i = 0; i < 11; i++) begin
      paddle_x = tbl[i].px; paddle_width = tbl[i].pw; paddle_y = tbl[i].py;
      x = tbl[i].pix_x; y = tbl[i].pix_y; active_pixels = tbl[i].act;
      step();
      check($sformatf("vec%0d_ball_x", i), 32'(ball_x), 32'(tbl[i].exp_bx));
      check($sformatf("vec%0d_ball_y", i), 32'(ball_y), 32'(tbl[i].exp_by));
      check($sformatf("vec%0d_color", i), 32'(vga_color), 32'(tbl[i].exp_col));
    end

    // one-cycle tracking latency
    paddle_x = 10'd300;
    #2;
    check("track_before_edge", 32'(ball_x), 32'd316);
    step();
    check("track_after_edge", 32'(ball_x), 32'd346);
    paddle_x = 10'd270;
    step();

    // button held through reset release must not launch
    launch_n = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (20) step();
    paddle_x = 10'd280;
    step();
    check("held_no_launch", 32'(ball_x), 32'd326);
    paddle_x = 10'd270;
    step();
    check("held_no_launch_back", 32'(ball_x), 32'd316);
    launch_n = 1'b1;
    repeat (6) step();

    // press: state changes on the third edge after the falling edge
    launch_n = 1'b0;
    repeat (2) step();
    paddle_x = 10'd280;
    step();
    check("launch_still_serve", 32'(ball_x), 32'd326);
    paddle_x = 10'd270;
    step();
    nvec++;
    if (ball_x !== 10'd326 && ball_x !== 10'd327) begin
      nfail++;
      $display("FAIL launch_now_moving: got ball_x %0d, expected 326 or 327", ball_x);
    end
    begin
      bit moved;
      moved = 0;
      for (int c = 0; c < STEP && !moved; c++) begin
        if (ball_y !== 10'd432) moved = 1;
        else step();
      end
      if (!moved) timeout("first_move");
    end
    check_pos("first_move", 10'd327, 10'd431);
    launch_n = 1'b1;

    // leg 1: right wall, top wall, down-left onto paddle at x=0 (right steer)
    paddle_x = 10'd0;
    wait_moves(863, "leg1_end", 10'd74, 10'd432);
    wait_moves(1, "steer_right", 10'd75, 10'd431);

    // leg 2: back down onto paddle centre (direction kept)
    paddle_x = 10'd290;
    wait_moves(863, "leg2_end", 10'd326, 10'd432);
    wait_moves(1, "steer_middle", 10'd325, 10'd431);

    // leg 3: left wall, top wall, down-right onto left of paddle (left steer)
    paddle_x = 10'd530;
    wait_moves(863, "leg3_end", 10'd538, 10'd432);
    wait_moves(1, "steer_left", 10'd537, 10'd431);

    // asynchronous reset mid-flight
    repeat (2) step();
    #3 rst = 1'b0;
    #1;
    check_pos("midflight_reset", 10'd316, 10'd432);
    check("midflight_reset_lives", 32'(lives), 32'd3);
    check("midflight_reset_game_over", 32'(game_over), 32'd0);
    check("midflight_reset_ball_lost", 32'(ball_lost), 32'd0);
    paddle_x = 10'd154;
    repeat (3) step();
    rst = 1'b1;
    repeat (6) step();
    check_pos("serve_154", 10'd200, 10'd432);

    // brick pulse in SERVE is discarded
    brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    step();
    launch_n = 1'b0;
    wait_moves(1, "serve_brick_discarded", 10'd201, 10'd431);
    launch_n = 1'b1;
    wait_moves(431, "corner_reach", 10'd632, 10'd0);

    // brick pulse coincident with the corner tick
    repeat (3) step();
    brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    check_pos("corner_brick", 10'd631, 10'd1);

    // sticky brick between ticks, then cleared
    wait_moves(2, "down_left", 10'd629, 10'd3);
    brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    wait_moves(1, "brick_sticky", 10'd628, 10'd2);
    wait_moves(1, "brick_cleared", 10'd627, 10'd1);
    wait_moves(2, "top_wall", 10'd625, 10'd1);

    // first miss
    paddle_x = 10'd400;
    wait_moves(471, "miss1_bottom", 10'd154, 10'd472);
    wait_lost(STEP, "miss1_pulse");
    check("miss1_lives", 32'(lives), 32'd2);
    check_pos("miss1_pos", 10'd154, 10'd472);
    step();
    check("miss1_pulse_width", 32'(ball_lost), 32'd0);
    repeat (479) step();
    check_pos("lost_frozen", 10'd154, 10'd472);
    step();
    check_pos("lost_exit_serve", 10'd446, 10'd432);

    // second miss (via left wall)
    launch_n = 1'b0;
    wait_lost(5000, "miss2_pulse");
    check("miss2_lives", 32'(lives), 32'd1);
    check_pos("miss2_pos", 10'd86, 10'd472);
    begin
      bit back;
      back = 0;
      for (int c = 0; c < 600 && !back; c++) begin
        step();
        if (ball_y === 10'd432) back = 1;
      end
      if (!back) timeout("miss2_serve");
    end
    check_pos("miss2_serve", 10'd446, 10'd432);

    // third miss -> game over
    launch_n = 1'b0;
    wait_lost(5000, "miss3_pulse");
    check("miss3_lives", 32'(lives), 32'd0);
    check_pos("miss3_pos", 10'd86, 10'd472);
    x = 10'd88; y = 10'd474; active_pixels = 1'b1;
    #1;
    check("lost_color_visible", 32'(vga_color), 32'hFFFFFF);
    begin
      bit over;
      over = 0;
      for (int c = 0; c < 600 && !over; c++) begin
        step();
        if (game_over === 1'b1) over = 1;
      end
      if (!over) timeout("game_over");
    end
    check("game_over_flag", 32'(game_over), 32'd1);
    check("game_over_color", 32'(vga_color), 32'd0);
    x = 10'd86; y = 10'd472;
    #1;
    check("game_over_color_corner", 32'(vga_color), 32'd0);
    launch_n = 1'b0;
    repeat (20) step();
    launch_n = 1'b1;
    check("game_over_sticky", 32'(game_over), 32'd1);
    check_pos("game_over_frozen", 10'd86, 10'd472);

    // reset leaves GAME_OVER
    #3 rst = 1'b0;
    #1;
    check("final_reset_game_over", 32'(game_over), 32'd0);
    check("final_reset_lives", 32'(lives), 32'd3);
    check_pos("final_reset", 10'd316, 10'd432);
    repeat (2) step();
    rst = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
